regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard, for the pipelined RISC-V core.
//  Serves NUM_RD combinational read ports to decode and NUM_WR write ports from writeback.
//  Tracks in-flight destination registers so issue logic can stall on RAW/WAW hazards, and can flush them on redirect.
// PARAMETERS
//  XLEN        32  data width of each register
//  NREGS       32  number of architectural registers (power of 2, >=2)
//  NUM_RD      2   read ports (1..4)
//  NUM_WR      2   write ports (1..2); higher index has priority
//  HARD_ZERO   1   1: register 0 reads 0, ignores writes, never busy
//  AW = $clog2(NREGS) derived localparam
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  rd_addr    in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data    out  NUM_RD*XLEN  read data, combinational from rd_addr
//  rd_busy    out  NUM_RD       1 = register at rd_addr[i] has a write in flight
//  wr_en      in   NUM_WR       write enable per port
//  wr_addr    in   NUM_WR*AW    write addresses
//  wr_data    in   NUM_WR*XLEN  write data
//  iss_valid  in   1            issue request: mark iss_rd busy
//  iss_rd     in   AW           destination register of issuing instruction
//  iss_ready  out  1            issue accepted this cycle
//  flush      in   1            clear all busy bits (pipeline redirect)
//  busy_cnt   out  AW+1         number of busy registers
// BEHAVIOUR
//  - Reset (rst_n low, async): all registers 0, all busy bits 0, busy_cnt 0; rd_data 0, rd_busy 0, iss_ready 1.
//  - Read: 0-cycle latency, combinational on rd_addr and register state; addr 0 with HARD_ZERO gives 0.
//  - Write: committed at posedge where wr_en[j]; visible on rd_data the following cycle.
//    Same addr on both write ports: port NUM_WR-1 wins. Addr 0 with HARD_ZERO: dropped.
//  - Write also clears busy[wr_addr] at the same edge; writing a non-busy register is legal, busy unchanged.
//  - Issue handshake: iss_ready = !busy[iss_rd] (registered state only, no same-cycle clear lookahead).
//    iss_valid && iss_ready sets busy[iss_rd] at the edge; iss_valid && !iss_ready: no state change, requester holds.
//    iss_rd = 0 with HARD_ZERO: iss_ready = 1, busy stays 0.
//  - Simultaneous set/clear on same reg (write to R while issue to R accepted): set wins, busy stays 1.
//  - flush: all busy bits 0 at the edge; overrides a same-cycle issue set; register writes that cycle still commit.
//  - busy_cnt: registered popcount, updated the same edge as the busy bits, always equals popcount(busy).
//  - rst_n asserted mid-operation: in-flight writes and issues are discarded; state returns to reset values at once.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN:
//   defined: rd_data[i] returns the write data of the winning port when wr_en matches rd_addr[i] (write-through),
//     and rd_busy[i] reads 0 for that register in the same cycle.
//   undefined: rd_data and rd_busy reflect registered state only; a write is seen one cycle later.
// STRUCTURE
//  - regfile_pkg: XLEN default, NREGS default, function clog2, reg_idx_t / xword_t typedefs.
//  - Sub-module rf_busy_table: busy bit vector, set/clear/flush priority, iss_ready, busy_cnt.
//  - regfile_mp: storage array, read muxes, write priority, optional bypass.
// TESTING
//  1. Reset: drive rst_n low mid-run with busy regs -> all reads 0, busy_cnt 0, iss_ready 1, asynchronously.
//  2. Write/read: wr0 x5=0xDEADBEEF -> rd_data(x5)=0xDEADBEEF the next cycle; write x0=0x1 -> x0 reads 0.
//  3. Port conflict: wr0 x7=0x11 and wr1 x7=0x22 same cycle -> x7 reads 0x22.
//  4. Scoreboard: issue x3 -> busy_cnt 1, rd_busy(x3)=1; re-issue x3 -> iss_ready 0;
//     write x3=0x9 -> busy 0, issue accepted next cycle.
//  5. Set/clear race and flush: write x4 while issuing x4 -> busy stays 1; flush with issue x6 -> busy_cnt 0.
//  6. Bypass (REGFILE_BYPASS_EN): write x9=0xCAFE while reading x9 -> same-cycle 0xCAFE, rd_busy 0;
//     without the macro -> old value that cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, helper function and typedefs for the multi-port register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // Ceiling log2, usable in constant expressions for port and index widths.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   typedef logic [clog2(NREGS_DEF)-1:0] reg_idx_t;
   typedef logic [XLEN_DEF-1:0]         xword_t;

endpackage

// File: rtl/rf_busy_table.sv
// Busy scoreboard: one bit per register, set by accepted issues, cleared by
// writeback and wiped by flush. Keeps a registered popcount alongside.
module rf_busy_table
   import regfile_pkg::*;
#(
   parameter int NREGS     = NREGS_DEF,
   parameter int NUM_WR    = 2,
   parameter int HARD_ZERO = 1,
   parameter int AW        = clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 flush,
   output logic [NREGS-1:0]     busy_vec,
   output logic                 iss_ready,
   output logic [AW:0]          busy_cnt
);

   logic [NREGS-1:0] r_busy;
   logic [AW:0]      r_cnt;
   logic [NREGS-1:0] w_clr;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_busy_next;
   logic [AW:0]      w_cnt_next;
   logic             w_ready;
   logic             w_iss_zero;

   // Issue acceptance looks at registered state only; register 0 is always ready when hard-wired.
   always_comb begin
      w_iss_zero = (HARD_ZERO != 0) && (iss_rd == '0);
      w_ready    = !r_busy[iss_rd] || w_iss_zero;
   end

   // Next busy vector: flush beats everything, an issue set beats a same-cycle write clear.
   always_comb begin
      w_clr = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j]) w_clr[wr_addr[j*AW +: AW]] = 1'b1;
      end
      w_set = '0;
      if (iss_valid && w_ready && !w_iss_zero) w_set[iss_rd] = 1'b1;
      w_busy_next = flush ? '0 : ((r_busy & ~w_clr) | w_set);
      w_cnt_next = '0;
      for (int k = 0; k < NREGS; k++) begin
         w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[k]};
      end
   end

   // Busy bits and their count update together so the count never lags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_next;
         r_cnt  <= w_cnt_next;
      end
   end

   assign busy_vec  = r_busy;
   assign iss_ready = w_ready;
   assign busy_cnt  = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through on reads and
// busy masking for registers being written this cycle.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int NREGS     = NREGS_DEF,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2,
   parameter int HARD_ZERO = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_RD*clog2(NREGS)-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0]           rd_data,
   output logic [NUM_RD-1:0]                rd_busy,
   input  logic [NUM_WR-1:0]                wr_en,
   input  logic [NUM_WR*clog2(NREGS)-1:0]   wr_addr,
   input  logic [NUM_WR*XLEN-1:0]           wr_data,
   input  logic                             iss_valid,
   input  logic [clog2(NREGS)-1:0]          iss_rd,
   output logic                             iss_ready,
   input  logic                             flush,
   output logic [clog2(NREGS):0]            busy_cnt
);

   localparam int AW = clog2(NREGS);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] w_busy_vec;

   rf_busy_table #(
      .NREGS     (NREGS),
      .NUM_WR    (NUM_WR),
      .HARD_ZERO (HARD_ZERO),
      .AW        (AW)
   ) u_busy (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .busy_vec  (w_busy_vec),
      .iss_ready (iss_ready),
      .busy_cnt  (busy_cnt)
   );

   // Register writes; later ports are applied last so the highest index wins a conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && !((HARD_ZERO != 0) && (wr_addr[j*AW +: AW] == '0))) begin
               r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [AW-1:0]   w_ra;
         logic [XLEN-1:0] w_rd_data;
         logic            w_rd_busy;

         assign w_ra = rd_addr[gi*AW +: AW];

         // Read mux for this port, with optional write-through and forced zero for x0.
         always_comb begin
            w_rd_data = r_regs[w_ra];
            w_rd_busy = w_busy_vec[w_ra];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*AW +: AW] == w_ra)) begin
                  w_rd_data = wr_data[j*XLEN +: XLEN];
                  w_rd_busy = 1'b0;
               end
            end
`else
`endif
            if ((HARD_ZERO != 0) && (w_ra == '0)) begin
               w_rd_data = '0;
               w_rd_busy = 1'b0;
            end
         end

         assign rd_data[gi*XLEN +: XLEN] = w_rd_data;
         assign rd_busy[gi]              = w_rd_busy;
      end
   endgenerate

endmodule
